// File: rtl/mic1_sequencer.sv
// mic1_sequencer: microsequencer in front of the 512x36 control store.
// It computes the next MPC from the current MIR (NEXT_ADDRESS, JMPC, JAMN,
// JAMZ), the ALU flags and MBR. It primes the store after reset, holds on
// datapath stalls and stops at HALT_ADDR.
//
// Handshake: the datapath executes mir whenever mir_valid=1. A
// microinstruction retires on a rising edge where mir_valid=1 and stall=0.
// While stall=1 the sequencer holds mpc, ucount and the store output.
module mic1_sequencer #(
  parameter logic [8:0] RESET_ADDR = 9'h000,
  parameter logic [8:0] HALT_ADDR  = 9'h1FF,
  parameter int         CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             cs_ren,
  output logic [8:0]       cs_raddr,
  input  logic [35:0]      cs_rdata,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic [7:0]       mbr,
  input  logic             stall,
  output logic [35:0]      mir,
  output logic             mir_valid,
  output logic [8:0]       mpc,
  output logic             halted,
  output logic [CNT_W-1:0] ucount,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [8:0]       mpc_q, mpc_d;
  logic [CNT_W-1:0] ucount_q, ucount_d;

  // Microinstruction fields taken straight from the registered store output.
  logic [8:0] na;
  logic       jmpc;
  logic       jamn;
  logic       jamz;
  logic [8:0] next_addr;
  logic       unused_fields;

  assign na            = cs_rdata[35:27];
  assign jmpc          = cs_rdata[26];
  assign jamn          = cs_rdata[25];
  assign jamz          = cs_rdata[24];
  assign unused_fields = ^cs_rdata[23:0];

  // Next-address logic: the JAM bits OR into bit 8, JMPC ORs MBR into the low byte.
  always_comb begin
    next_addr[8]   = na[8] | (jamn & alu_n) | (jamz & alu_z);
    next_addr[7:0] = jmpc ? (na[7:0] | mbr) : na[7:0];
  end

  // FSM next-state and outputs. The store address is steered so that the
  // word read this cycle is the microinstruction that executes next cycle.
  always_comb begin
    state_d   = state_q;
    mpc_d     = mpc_q;
    ucount_d  = ucount_q;
    cs_ren    = 1'b0;
    cs_raddr  = mpc_q;
    mir_valid = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_PRIME: begin
        cs_ren   = 1'b1;
        cs_raddr = RESET_ADDR;
        state_d  = ST_RUN;
        mpc_d    = RESET_ADDR;
      end
      ST_RUN: begin
        mir_valid = 1'b1;
        cs_raddr  = next_addr;
        // A halt target is never fetched, so mir keeps the last microinstruction.
        cs_ren    = ~stall & (next_addr != HALT_ADDR);
        if (!stall) begin
          mpc_d    = next_addr;
          ucount_d = ucount_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (next_addr == HALT_ADDR) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_PRIME;
      end
    endcase
  end

  // State, MPC and retire-counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PRIME;
      mpc_q    <= RESET_ADDR;
      ucount_q <= '0;
    end else begin
      state_q  <= state_d;
      mpc_q    <= mpc_d;
      ucount_q <= ucount_d;
    end
  end

  assign mir       = cs_rdata;
  assign mpc       = mpc_q;
  assign ucount    = ucount_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mic1_sequencer.md
Name: mic1_sequencer

Overview:
- Microsequencer that sits directly upstream of the 512x36 control store. It drives the store's read address and enable, and treats the store's registered output as the MIR.
- Each cycle it computes the next MPC from the current microinstruction's NEXT_ADDRESS and JAM fields, the datapath N/Z flags and MBR, so one microinstruction issues per clock.
- It handles the post-reset prime, datapath stalls, and a halt address.

Parameters:
- RESET_ADDR, 9'h000, first microinstruction address fetched after reset.
- HALT_ADDR, 9'h1FF, next-address value that stops sequencing.
- CNT_W, 32, width of the retired-microinstruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cs_ren  out  1  control store read enable.
- cs_raddr  out  9  control store read address.
- cs_rdata  in  36  control store registered read data (the MIR).
- alu_n  in  1  ALU negative flag for the current microinstruction.
- alu_z  in  1  ALU zero flag for the current microinstruction.
- mbr  in  8  memory byte register, used by JMPC.
- stall  in  1  datapath is waiting; the current microinstruction must not retire.
- mir  out  36  pass-through of cs_rdata to the datapath.
- mir_valid  out  1  mir holds a microinstruction to execute this cycle.
- mpc  out  9  address of the microinstruction currently in mir.
- halted  out  1  sequencer has stopped at HALT_ADDR.
- ucount  out  CNT_W  number of retired microinstructions.

Behaviour:
- Microinstruction fields:
  - NA = cs_rdata[35:27]
  - JMPC = [26], JAMN = [25], JAMZ = [24]
  - [23:0] are not used by this block.
- Next address:
  - next[8] = NA[8] | (JAMN & alu_n) | (JAMZ & alu_z).
  - next[7:0] = JMPC ? (NA[7:0] | mbr) : NA[7:0].
  - Purely combinational from the current mir and inputs.
- States: PRIME, RUN, HALT. rst forces PRIME asynchronously.
- Reset values: state=PRIME, mpc=RESET_ADDR, ucount=0, halted=0, mir_valid=0.
- PRIME:
  - cs_ren=1, cs_raddr=RESET_ADDR, mir_valid=0.
  - At the next edge go to RUN and set mpc=RESET_ADDR (cs_rdata now holds mem[RESET_ADDR]).
  - stall is ignored in PRIME.
- RUN:
  - mir_valid=1, cs_raddr=next.
  - cs_ren = ~stall & (next != HALT_ADDR).
  - Retire = edge with stall=0. On retire: mpc<=next, ucount<=ucount+1 (wraps modulo 2^CNT_W).
  - If next==HALT_ADDR at retire, go to HALT. The store is not read, so mir retains the last microinstruction.
  - If stall=1: no retire; mpc and ucount are held. cs_ren=0, so the store output, and therefore mir, are held.
  - The datapath keeps alu_n, alu_z and mbr stable until the retiring edge. Values sampled at the retiring edge decide the branch.
- Latency: an address presented on cs_raddr in cycle k appears on mir in cycle k+1. There are no bubbles between unstalled microinstructions.
- HALT:
  - halted=1, mir_valid=0, cs_ren=0, cs_raddr=mpc.
  - mpc and ucount are frozen.
  - HALT is left only via rst.
- cs_raddr outside RUN/PRIME equals mpc.
- mir = cs_rdata at all times. It has no reset value of its own.
- Reset mid-operation (any state, including during stall):
  - Outputs take their reset values immediately.
  - On rst release, PRIME re-reads RESET_ADDR.
- Simultaneous stall=1 with next==HALT_ADDR: stay in RUN. The halt happens on the edge where stall falls.
- JMPC with NA[7:0]=0 gives next[7:0]=mbr. NA[8] is still ORed into bit 8.

Test Plan:
- Reset/prime: hold rst, release; store mem[0]=NA 9'h005, JAM 0 -> cycle 1 cs_raddr=0 with cs_ren=1; cycle 2 mir_valid=1, mpc=0, cs_raddr=5; next edge mpc=5, ucount=1.
- JAMZ: mir NA=9'h010, JAMZ=1; alu_z=1 -> cs_raddr=9'h110; with alu_z=0 -> 9'h010. Repeat for JAMN with alu_n, and with both flags set -> 9'h110.
- JMPC: NA=9'h100, JMPC=1, mbr=8'h3C -> cs_raddr=9'h13C, and mpc=9'h13C after the edge.
- Stall: assert stall for 3 cycles mid-RUN -> cs_ren=0, mir/mpc/ucount unchanged for all 3 cycles; ucount increments once only, on the edge where stall=0.
- Halt: chain reaching next=9'h1FF -> halted=1, mir_valid=0, cs_ren=0, ucount frozen; stall=1 with next=HALT_ADDR delays halt until stall drops.
- Async reset mid-stall and in HALT: pulse rst between clock edges -> mir_valid=0, halted=0, ucount=0, mpc=RESET_ADDR immediately; PRIME resumes on release.
